gpu_rect_fetcher: RTL and testbench

GPU-side reader for the rectangle descriptor RAM. The CPU fills the RAM through its write port. On a `start` pulse, this block sweeps the read port and reassembles each 6-word descriptor into one parallel record. It presents each record to the downstream rasterizer over a valid/ready handshake and pulses `done` when the sweep ends.

---
 rtl/gpu_pkg.sv | 31 +++
 rtl/gpu_rect_fetcher.sv | 152 +++++++++++++++
 tb/tb_gpu_rect_fetcher.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the rectangle descriptor fetcher.
package gpu_pkg;

    localparam int unsigned RECT_WORDS  = 6;
    localparam int unsigned RECT_COUNT  = 64;
    localparam int unsigned DATA_W      = 16;

    localparam int unsigned RECT_OFS_EN    = 0;
    localparam int unsigned RECT_OFS_X     = 1;
    localparam int unsigned RECT_OFS_Y     = 2;
    localparam int unsigned RECT_OFS_W     = 3;
    localparam int unsigned RECT_OFS_H     = 4;
    localparam int unsigned RECT_OFS_COLOR = 5;

    typedef struct packed {
        logic              en;
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] w;
        logic [DATA_W-1:0] h;
        logic [DATA_W-1:0] color;
    } rect_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/gpu_rect_fetcher.sv
// Sweeps the descriptor RAM and presents each 6-word descriptor as one record.
// Optional: GPU_RECT_SKIP_DISABLED_EN drops descriptors whose enable bit is 0.
module gpu_rect_fetcher
    import gpu_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter int unsigned RECT_COUNT = gpu_pkg::RECT_COUNT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_dout,
    output logic        rect_valid,
    input  logic        rect_ready,
    output logic [5:0]  rect_index,
    output logic        rect_en,
    output logic [15:0] rect_x,
    output logic [15:0] rect_y,
    output logic [15:0] rect_w,
    output logic [15:0] rect_h,
    output logic [15:0] rect_color,
    output logic        rect_last,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0]  LAST_R    = 6'(RECT_COUNT - 1);
    localparam logic [15:0] STRIDE    = 16'(RECT_WORDS);
    localparam logic [2:0]  W_FINAL   = 3'(RECT_WORDS);
    localparam logic [2:0]  W_LASTADR = 3'(RECT_WORDS - 1);

    state_t      state;
    logic [2:0]  w_cnt;
    logic [5:0]  r_cnt;
    logic [15:0] rec_base;
    rect_t       cap_q;
    rect_t       out_q;
    logic [15:0] mem_addr_q;
    logic [5:0]  index_q;
    logic        valid_q;
    logic        last_q;
    logic        busy_q;
    logic        done_q;
    logic        skip_c;

    // A disabled descriptor is only dropped when the skip feature is built in.
    always_comb begin
        skip_c = 1'b0;
`ifdef GPU_RECT_SKIP_DISABLED_EN
        skip_c = ~cap_q.en;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            w_cnt      <= '0;
            r_cnt      <= '0;
            rec_base   <= '0;
            cap_q      <= '0;
            out_q      <= '0;
            mem_addr_q <= '0;
            index_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (start) begin
                        state      <= ST_FETCH;
                        w_cnt      <= '0;
                        r_cnt      <= '0;
                        rec_base   <= BASE_ADDR;
                        mem_addr_q <= BASE_ADDR;
                        busy_q     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // Data for the address issued at w-1 arrives at w.
                    case (w_cnt)
                        3'(RECT_OFS_EN + 1): cap_q.en <= mem_dout[0];
                        3'(RECT_OFS_X + 1):  cap_q.x  <= mem_dout;
                        3'(RECT_OFS_Y + 1):  cap_q.y  <= mem_dout;
                        3'(RECT_OFS_W + 1):  cap_q.w  <= mem_dout;
                        3'(RECT_OFS_H + 1):  cap_q.h  <= mem_dout;
                        default: ;
                    endcase
                    if (w_cnt < W_FINAL) begin
                        w_cnt      <= w_cnt + 3'd1;
                        mem_addr_q <= (w_cnt < W_LASTADR) ? rec_base + 16'(w_cnt) + 16'd1 : 16'd0;
                    end else if (skip_c) begin
                        if (r_cnt == LAST_R) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            r_cnt      <= r_cnt + 6'd1;
                            w_cnt      <= '0;
                            rec_base   <= rec_base + STRIDE;
                            mem_addr_q <= rec_base + STRIDE;
                        end
                    end else begin
                        state   <= ST_EMIT;
                        out_q   <= {cap_q.en, cap_q.x, cap_q.y, cap_q.w, cap_q.h, mem_dout};
                        index_q <= r_cnt;
                        last_q  <= (r_cnt == LAST_R);
                        valid_q <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (rect_ready) begin
                        valid_q <= 1'b0;
                        if (r_cnt == LAST_R) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= ST_FETCH;
                            r_cnt      <= r_cnt + 6'd1;
                            w_cnt      <= '0;
                            rec_base   <= rec_base + STRIDE;
                            mem_addr_q <= rec_base + STRIDE;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign rect_valid = valid_q;
    assign rect_index = index_q;
    assign rect_en    = out_q.en;
    assign rect_x     = out_q.x;
    assign rect_y     = out_q.y;
    assign rect_w     = out_q.w;
    assign rect_h     = out_q.h;
    assign rect_color = out_q.color;
    assign rect_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_gpu_rect_fetcher.sv
// Self-checking bench for gpu_rect_fetcher against a descriptor-list reference model.
module tb_gpu_rect_fetcher;

    localparam logic [15:0] BASE = 16'h0100;
    localparam int NREC = 64;
`ifdef GPU_RECT_SKIP_DISABLED_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] mem_addr;
    logic [15:0] mem_dout;
    logic        rect_valid;
    logic        rect_ready;
    logic [5:0]  rect_index;
    logic        rect_en;
    logic [15:0] rect_x, rect_y, rect_w, rect_h, rect_color;
    logic        rect_last;
    logic        busy;
    logic        done;

    logic [15:0] ram [0:65535];

    gpu_rect_fetcher #(.BASE_ADDR(BASE), .RECT_COUNT(NREC)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_addr(mem_addr), .mem_dout(mem_dout),
        .rect_valid(rect_valid), .rect_ready(rect_ready),
        .rect_index(rect_index), .rect_en(rect_en),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
        .rect_color(rect_color), .rect_last(rect_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data appears the cycle after the address.
    always @(posedge clk) mem_dout <= ram[mem_addr];

    typedef struct packed {
        logic [5:0]  idx;
        logic        en;
        logic [15:0] x, y, w, h, c;
        logic        last;
    } rec_t;

    rec_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({mem_addr, rect_valid, rect_index, rect_en, rect_x, rect_y, rect_w,
                     rect_h, rect_color, rect_last, busy, done});
    endfunction

    function automatic logic [15:0] waddr(input int n, input int k);
        return 16'(int'(BASE) + 6 * n + k);
    endfunction

    // mode 0: basic/full-sweep contents; mode 1: random contents, records 0..4 enabled.
    task automatic fill(input int mode);
        for (int n = 0; n < NREC; n++) begin
            logic en;
            if (mode == 0) en = !(n == 1 || n == 63);
            else           en = (n <= 4) ? 1'b1 : 1'($urandom);
            for (int k = 0; k < 6; k++) ram[waddr(n, k)] = 16'($urandom);
            ram[waddr(n, 0)] = {ram[waddr(n, 0)][15:1], en};
            if (mode == 0) ram[waddr(n, 3)] = 16'(16'h0100 - 4 * n);
        end
        if (mode == 0) begin
            ram[waddr(0, 0)] = 16'h0001;
            ram[waddr(0, 1)] = 16'h0000;
            ram[waddr(0, 2)] = 16'h0000;
            ram[waddr(0, 3)] = 16'h0100;
            ram[waddr(0, 4)] = 16'h0100;
            ram[waddr(0, 5)] = 16'h3900;
        end
    endtask

    // Expected record list and sweep length in cycles (8 per emitted, 7 per skipped).
    task automatic build_model(output int cost);
        rec_t r;
        expq.delete();
        cost = 0;
        for (int n = 0; n < NREC; n++) begin
            r.idx  = 6'(n);
            r.en   = ram[waddr(n, 0)][0];
            r.x    = ram[waddr(n, 1)];
            r.y    = ram[waddr(n, 2)];
            r.w    = ram[waddr(n, 3)];
            r.h    = ram[waddr(n, 4)];
            r.c    = ram[waddr(n, 5)];
            r.last = (n == NREC - 1);
            if (SKIP && !r.en) cost += 7;
            else begin
                expq.push_back(r);
                cost += 8;
            end
        end
    endtask

    task automatic run_sweep(input int stall_idx, input int stall_len, input bit check_addr,
                             input int reset_cyc);
        int   cost, cyc, stall_left, done_exp, exp_addr;
        bit   done_seen, late_done;
        rec_t cur;
        build_model(cost);
        done_exp   = 1 + cost + ((stall_idx >= 0) ? stall_len : 0);
        stall_left = stall_len;
        done_seen  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 3000) begin
            if (check_addr && cyc <= 9) begin
                exp_addr = (cyc <= 6) ? int'(BASE) + cyc - 1 : (cyc == 9) ? int'(BASE) + 6 : 0;
                check("mem_addr", 128'(mem_addr), 128'(exp_addr));
            end
            if (check_addr && cyc <= 8)
                check("first_valid", 128'(rect_valid), 128'(cyc == 8));
            if (reset_cyc != 0 && cyc == 20) start = 1'b1;
            rect_ready = 1'($urandom);
            if (rect_valid) begin
                if (expq.size() == 0) begin
                    check("extra_record", 128'(rect_index), 128'(0) - 128'(1));
                end else begin
                    cur = expq[0];
                    check("record", 128'({rect_index, rect_en, rect_x, rect_y, rect_w, rect_h,
                                          rect_color, rect_last}), 128'(cur));
                    if (int'(cur.idx) == stall_idx && stall_left > 0) begin
                        rect_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rect_ready = 1'b1;
                        void'(expq.pop_front());
                    end
                end
            end
            if (done) begin
                done_seen = 1'b1;
                check("done_cycle", 128'(cyc), 128'(reset_cyc != 0 ? 0 : done_exp));
                check("busy_at_done", 128'(busy), 128'(1));
                check("all_emitted", 128'(expq.size()), 128'(0));
            end
            if (reset_cyc != 0 && cyc == reset_cyc) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                start = 1'b0;
                check("reset_outputs", all_outs(), 128'(0));
                late_done = 1'b0;
                repeat (10) begin
                    tick();
                    if (done) late_done = 1'b1;
                end
                check("no_done_after_reset", 128'(late_done), 128'(0));
                check("idle_after_reset", 128'(busy), 128'(0));
                return;
            end
            if (!done_seen) begin
                tick();
                start = 1'b0;
                cyc++;
            end
        end
        check("done_seen", 128'(done_seen), 128'(1));
        tick();
        check("busy_after_done", 128'({busy, done}), 128'(0));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        rect_ready = 1'b0;
        repeat (3) tick();
        check("reset_state", all_outs(), 128'(0));
        reset = 1'b0;
        tick();

        fill(0);
        run_sweep(-1, 0, 1'b1, 0);
        fill(1);
        run_sweep(3, 5, 1'b0, 0);
        fill(1);
        run_sweep(-1, 0, 1'b0, 100);
        run_sweep(-1, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
